// File: rtl/dataflow_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dataflow_stage_sequencer
// Brief  : ap_ctrl_hs start/ready/done sequencing for a PROC_NUM-stage
//          dataflow region, with start-token counters and no-progress watchdogs.
// Rev    : 1.0
// ============================================================================

module dataflow_stage_sequencer #(
  parameter int PROC_NUM    = 2,
  parameter int START_DEPTH = 2,
  parameter int MAX_INFL    = 4,
  parameter int WDOG_CYC    = 1024
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  output logic                ap_idle,
  output logic [PROC_NUM-1:0] proc_start,
  input  logic [PROC_NUM-1:0] proc_ready,
  input  logic [PROC_NUM-1:0] proc_done,
  input  logic [PROC_NUM-1:0] proc_idle,
  output logic [PROC_NUM-1:0] blk_vec,
  output logic                stalled,
  output logic [31:0]         iter_cnt
);

  localparam int              WD_W       = $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] C_WD_MAX   = WD_W'(WDOG_CYC - 1);
  localparam logic [WD_W-1:0] C_WD_ONE   = WD_W'(1);
  localparam logic [3:0]      C_DEPTH    = 4'(START_DEPTH);
  localparam logic [3:0]      C_MAX_INFL = 4'(MAX_INFL);
  localparam int              LAST       = PROC_NUM - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_tok [PROC_NUM];
  logic [3:0]      r_inflight;
  logic [WD_W-1:0] r_wd [PROC_NUM];

  logic [PROC_NUM-1:0] w_tok_nz;
  logic [PROC_NUM-1:0] w_down_full;
  logic [PROC_NUM-1:0] w_acc;
  logic [PROC_NUM-1:0] w_acc_up;
  logic [PROC_NUM-1:0] w_wd_clr;
  logic [PROC_NUM-1:0] w_wd_exp;
  logic                w_stall;
  logic                w_run;
  logic                w_dec;
  logic [3:0]          w_inflight_nxt;

  assign w_stall = (r_state == S_STALL);
  assign w_run   = (r_state == S_RUN);

  // r_tok[0] has no upstream producer and is held at zero.
  for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_stage
    assign w_tok_nz[gi] = (r_tok[gi] != 4'd0);
    if (gi == LAST) begin : g_last
      assign w_down_full[gi] = 1'b0;
    end else begin : g_mid
      assign w_down_full[gi] = (r_tok[gi+1] == C_DEPTH);
    end
    if (gi == 0) begin : g_first
      assign w_acc_up[gi]   = 1'b0;
      assign proc_start[gi] = ap_start & (r_inflight < C_MAX_INFL) & ~w_down_full[gi] & ~w_stall;
    end else begin : g_next
      assign w_acc_up[gi]   = w_acc[gi-1];
      assign proc_start[gi] = w_tok_nz[gi] & ~w_down_full[gi] & ~w_stall;
    end
    assign w_wd_clr[gi] = w_acc[gi] | proc_done[gi] | (proc_idle[gi] & ~proc_start[gi]);
    assign w_wd_exp[gi] = w_run & (r_wd[gi] == C_WD_MAX);
  end

  assign w_acc    = proc_start & proc_ready;
  assign ap_ready = w_acc[0];
  assign ap_idle  = (r_inflight == 4'd0) & (&proc_idle) & ~(|w_tok_nz);
  assign stalled  = |blk_vec;
  // A last-stage done with nothing in flight must not wrap the counter.
  assign w_dec    = proc_done[LAST] & (r_inflight != 4'd0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_acc[0], w_dec})
      2'b10:   w_inflight_nxt = r_inflight + 4'd1;
      2'b01:   w_inflight_nxt = r_inflight - 4'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_inflight <= 4'd0;
      ap_done    <= 1'b0;
      iter_cnt   <= 32'd0;
      blk_vec    <= '0;
      for (int k = 0; k < PROC_NUM; k++) begin
        r_tok[k] <= 4'd0;
        r_wd[k]  <= '0;
      end
    end else begin
      r_inflight <= w_inflight_nxt;
      ap_done    <= proc_done[LAST];
      if (proc_done[LAST]) iter_cnt <= iter_cnt + 32'd1;
      blk_vec <= blk_vec | w_wd_exp;
      for (int k = 0; k < PROC_NUM; k++) begin
        if (k != 0) begin
          case ({w_acc_up[k], w_acc[k]})
            2'b10:   r_tok[k] <= r_tok[k] + 4'd1;
            2'b01:   r_tok[k] <= r_tok[k] - 4'd1;
            default: r_tok[k] <= r_tok[k];
          endcase
        end
        // Watchdogs run only in S_RUN and freeze once stalled.
        if (r_state == S_IDLE) r_wd[k] <= '0;
        else if (w_run)        r_wd[k] <= w_wd_clr[k] ? '0 : r_wd[k] + C_WD_ONE;
      end
      case (r_state)
        S_IDLE:  if (w_acc[0]) r_state <= S_RUN;
        S_RUN: begin
          if (|w_wd_exp)                                  r_state <= S_STALL;
          else if ((w_inflight_nxt == 4'd0) && !w_acc[0]) r_state <= S_IDLE;
        end
        S_STALL: r_state <= S_STALL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dataflow_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dataflow_stage_sequencer
// Brief  : Self-checking bench: vector table, directed multi-cycle sequences
//          and randomized stimulus against a behavioural model.
// Rev    : 1.0
// ============================================================================

module tb_dataflow_stage_sequencer;

  localparam int P     = 2;
  localparam int DEPTH = 2;
  localparam int MAXI  = 4;
  localparam int WD_A  = 1024;
  localparam int WD_B  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_ready, a_done, a_idle, a_stalled;
  logic [P-1:0] a_ps, a_prdy, a_pdone, a_pidle, a_blk;
  logic [31:0] a_iter;
  logic b_start, b_ready, b_done, b_idle, b_stalled;
  logic [P-1:0] b_ps, b_prdy, b_pdone, b_pidle, b_blk;
  logic [31:0] b_iter;

  dataflow_stage_sequencer #(.PROC_NUM(P), .START_DEPTH(DEPTH), .MAX_INFL(MAXI), .WDOG_CYC(WD_A)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done),
    .ap_idle(a_idle), .proc_start(a_ps), .proc_ready(a_prdy), .proc_done(a_pdone),
    .proc_idle(a_pidle), .blk_vec(a_blk), .stalled(a_stalled), .iter_cnt(a_iter));

  dataflow_stage_sequencer #(.PROC_NUM(P), .START_DEPTH(DEPTH), .MAX_INFL(MAXI), .WDOG_CYC(WD_B)) dut_wd (
    .ap_clk(clk), .ap_rst(rst), .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done),
    .ap_idle(b_idle), .proc_start(b_ps), .proc_ready(b_prdy), .proc_done(b_pdone),
    .proc_idle(b_pidle), .blk_vec(b_blk), .stalled(b_stalled), .iter_cnt(b_iter));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic s, input logic [P-1:0] r, input logic [P-1:0] d, input logic [P-1:0] id);
    a_start = s;
    a_prdy  = r;
    a_pdone = d;
    a_pidle = id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_a(1'b0, 2'b00, 2'b00, 2'b11);
    b_start = 1'b0; b_prdy = 2'b00; b_pdone = 2'b00; b_pidle = 2'b11;
    step();
    rst = 1'b0;
  endtask

  // ---------------- single-iteration vector table ----------------
  typedef struct {
    logic       st;
    logic [1:0] rdy;
    logic [1:0] dn;
    logic [1:0] idl;
    logic [1:0] e_ps;
    logic       e_rdy;
    logic       e_done;
    logic       e_idle;
    logic [31:0] e_iter;
  } vec_t;

  vec_t tbl [8];

  task automatic run_table(input string tag);
    for (int r = 0; r < 8; r++) begin
      drive_a(tbl[r].st, tbl[r].rdy, tbl[r].dn, tbl[r].idl);
      #1;
      check({tag, "_ps"},   32'(a_ps),    32'(tbl[r].e_ps));
      check({tag, "_rdy"},  32'(a_ready), 32'(tbl[r].e_rdy));
      check({tag, "_done"}, 32'(a_done),  32'(tbl[r].e_done));
      check({tag, "_idle"}, 32'(a_idle),  32'(tbl[r].e_idle));
      check({tag, "_iter"}, a_iter,       tbl[r].e_iter);
      step();
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_tok [P];
  int          m_wd [P];
  int          m_infl;
  int          m_mode;   // 0 idle, 1 running, 2 stalled
  logic [P-1:0] m_blk, m_ps, m_acc;
  logic        m_done, m_idle;
  logic [31:0] m_iter;

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_tok[i] = 0;
      m_wd[i]  = 0;
    end
    m_infl = 0; m_mode = 0; m_blk = '0; m_done = 1'b0; m_iter = 32'd0;
  endtask

  task automatic model_comb();
    int   tsum;
    logic full_dn;
    tsum = 0;
    for (int i = 0; i < P; i++) begin
      if (i < P - 1) full_dn = (m_tok[i+1] == DEPTH);
      else           full_dn = 1'b0;
      if (i == 0) m_ps[i] = a_start && (m_infl < MAXI) && !full_dn && (m_mode != 2);
      else        m_ps[i] = (m_tok[i] > 0) && !full_dn && (m_mode != 2);
      tsum += m_tok[i];
    end
    m_acc  = m_ps & a_prdy;
    m_idle = (m_infl == 0) && (&a_pidle) && (tsum == 0);
  endtask

  task automatic model_edge();
    logic [P-1:0] expd;
    int prev;
    if (rst) begin
      model_reset();
      return;
    end
    expd = '0;
    for (int i = 0; i < P; i++) expd[i] = (m_mode == 1) && (m_wd[i] == WD_A - 1);
    for (int i = 0; i < P; i++) begin
      if (m_mode == 1) begin
        if (m_acc[i] || a_pdone[i] || (a_pidle[i] && !m_ps[i])) m_wd[i] = 0;
        else m_wd[i] = m_wd[i] + 1;
      end else if (m_mode == 0) begin
        m_wd[i] = 0;
      end
    end
    for (int i = 1; i < P; i++) m_tok[i] = m_tok[i] + (m_acc[i-1] ? 1 : 0) - (m_acc[i] ? 1 : 0);
    prev   = m_infl;
    m_infl = prev + (m_acc[0] ? 1 : 0) - ((a_pdone[P-1] && prev > 0) ? 1 : 0);
    if (m_mode == 0 && m_acc[0]) m_mode = 1;
    else if (m_mode == 1) begin
      if (|expd) m_mode = 2;
      else if (m_infl == 0 && !m_acc[0]) m_mode = 0;
    end
    m_blk  = m_blk | expd;
    m_done = a_pdone[P-1];
    if (m_done) m_iter = m_iter + 32'd1;
  endtask

  // ---------------- main sequence ----------------
  logic rdy_hist [56];
  logic done_hist [56];
  logic [31:0] iter_at55;
  int n_acc;
  int n_bad;

  initial begin
    tbl[0] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[1] = '{1'b1, 2'b01, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[2] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[3] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[4] = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[6] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 32'd1};
    tbl[7] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1};

    rst = 1'b1;
    drive_a(1'b0, 2'b00, 2'b00, 2'b11);
    b_start = 1'b0; b_prdy = 2'b00; b_pdone = 2'b00; b_pidle = 2'b11;
    step();
    rst = 1'b0;
    #1;
    check("rst_blk",     32'(a_blk),     0);
    check("rst_stalled", 32'(a_stalled), 0);

    // T1: one iteration through the table
    run_table("t1");

    // T5: watchdog on stage 1 (WDOG_CYC=16 instance)
    b_start = 1'b1; b_prdy = 2'b01; b_pidle = 2'b01;
    #1;
    check("t5_accept", 32'(b_ready), 1);
    step();
    b_start = 1'b0; b_prdy = 2'b00;
    for (int k = 1; k <= 18; k++) begin
      #1;
      check("t5_blk",     32'(b_blk),     (k >= 17) ? 2 : 0);
      check("t5_stalled", 32'(b_stalled), (k >= 17) ? 1 : 0);
      check("t5_ps",      32'(b_ps),      (k >= 17) ? 0 : 2);
      step();
    end
    b_start = 1'b1; b_prdy = 2'b11;
    #1;
    check("t5_ps_frozen", 32'(b_ps), 0);

    // T2: stage 1 never ready, token counter fills to 2
    do_reset();
    drive_a(1'b1, 2'b01, 2'b00, 2'b11);
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (a_ready) n_acc++;
      step();
    end
    #1;
    check("t2_accepts", 32'(n_acc),   2);
    check("t2_ps",      32'(a_ps),    2);
    check("t2_ready",   32'(a_ready), 0);
    step();
    drive_a(1'b1, 2'b11, 2'b00, 2'b11);
    #1;
    check("t2_full_ready", 32'(a_ready), 0);
    step();
    #1;
    check("t2_drain_ready", 32'(a_ready), 1);

    // T3/T4: in-flight limit, then accept coinciding with last-stage done
    do_reset();
    drive_a(1'b1, 2'b11, 2'b00, 2'b00);
    for (int idx = 0; idx < 56; idx++) begin
      a_pdone = (idx == 50 || idx == 52 || idx == 53) ? 2'b10 : 2'b00;
      #1;
      rdy_hist[idx]  = a_ready;
      done_hist[idx] = a_done;
      if (idx == 55) iter_at55 = a_iter;
      step();
    end
    n_acc = 0;
    n_bad = 0;
    for (int idx = 0; idx <= 50; idx++) begin
      if (rdy_hist[idx]) n_acc++;
      if (idx >= 4 && rdy_hist[idx]) n_bad++;
    end
    check("t3_accepts",     32'(n_acc), 4);
    check("t3_ready_held0", 32'(n_bad), 0);
    check("t3_ready_51",    32'(rdy_hist[51]), 1);
    check("t3_done_51",     32'(done_hist[51]), 1);
    check("t4_ready_52",    32'(rdy_hist[52]), 0);
    check("t4_ready_53",    32'(rdy_hist[53]), 1);
    check("t4_ready_54",    32'(rdy_hist[54]), 1);
    check("t4_ready_55",    32'(rdy_hist[55]), 0);
    check("t4_iter",        iter_at55, 3);
    drive_a(1'b0, 2'b11, 2'b10, 2'b11);
    for (int c = 0; c < 6; c++) step();
    a_pdone = 2'b00;
    step();
    #1;
    check("t4_drained_idle", 32'(a_idle), 1);
    step();

    // T6: reset mid-iteration with tok[1]=1 and two in flight
    drive_a(1'b1, 2'b01, 2'b00, 2'b00);
    #1;
    check("t6_acc0", 32'(a_ready), 1);
    step();
    drive_a(1'b1, 2'b11, 2'b00, 2'b00);
    #1;
    check("t6_acc1_ps", 32'(a_ps), 3);
    step();
    #1;
    check("t6_busy_idle", 32'(a_idle), 0);
    rst = 1'b1;
    drive_a(1'b0, 2'b00, 2'b00, 2'b00);
    step();
    rst = 1'b0;
    drive_a(1'b0, 2'b00, 2'b00, 2'b11);
    #1;
    check("t6_ready",   32'(a_ready),   0);
    check("t6_done",    32'(a_done),    0);
    check("t6_idle",    32'(a_idle),    1);
    check("t6_ps",      32'(a_ps),      0);
    check("t6_stalled", 32'(a_stalled), 0);
    check("t6_iter",    a_iter,         0);
    step();
    run_table("t6_restart");

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      a_start = 1'($urandom_range(0, 1));
      a_prdy  = 2'($urandom);
      a_pdone = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      a_pidle = 2'($urandom);
      #1;
      model_comb();
      check("rnd_ps",      32'(a_ps),      32'(m_ps));
      check("rnd_ready",   32'(a_ready),   32'(m_acc[0]));
      check("rnd_idle",    32'(a_idle),    32'(m_idle));
      check("rnd_done",    32'(a_done),    32'(m_done));
      check("rnd_iter",    a_iter,         m_iter);
      check("rnd_blk",     32'(a_blk),     32'(m_blk));
      check("rnd_stalled", 32'(a_stalled), 32'(|m_blk));
      model_edge();
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
